// File: rtl/sp_ram_stream_pkg.sv
// Shared definitions for the sp_ram stream reader.
// Holds the reader FSM state encoding and width helpers used by the reader
// top and its output FIFO.
//   ST_IDLE / ST_ISSUE / ST_DRAIN / ST_DONE : 2-bit FSM state encoding
//   addrWidthOf(depth)    : address width for a RAM of 'depth' words
//   fifoCntWidthOf(depth) : width of a counter holding 0..depth
package sp_ram_stream_pkg;

  localparam int STATE_W = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic int addrWidthOf(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int fifoCntWidthOf(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sp_ram_stream_reader_fifo.sv
// stream_fifo: small synchronous FIFO that buffers RAM read data in front of
// the output stream.
// Ports:
//   clkIn, rstIn      : clock (rising edge), asynchronous active-low reset
//   pushIn/pushDataIn : write one word
//   popIn             : remove the head word (ignored when empty)
//   headOut           : current head word (storage is cleared on reset)
//   countOut          : number of stored words, 0..FIFO_DEPTH
module stream_fifo
  import sp_ram_stream_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  parameter int  FIFO_DEPTH = 2,
  localparam int CNT_W      = fifoCntWidthOf(FIFO_DEPTH)
) (
  input  logic                  clkIn,
  input  logic                  rstIn,
  input  logic                  pushIn,
  input  logic [DATA_WIDTH-1:0] pushDataIn,
  input  logic                  popIn,
  output logic [DATA_WIDTH-1:0] headOut,
  output logic [CNT_W-1:0]      countOut
);

  localparam int               PTR_W    = addrWidthOf(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wrPtr;
  logic [PTR_W-1:0]      rdPtr;
  logic [CNT_W-1:0]      count;
  logic                  doPush;
  logic                  doPop;

  // A push into a full FIFO is only legal when a pop frees a slot the same cycle.
  assign doPop    = popIn && (count != '0);
  assign doPush   = pushIn && ((count != FULL_CNT) || doPop);
  assign headOut  = mem[rdPtr];
  assign countOut = count;

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= pushDataIn;
        wrPtr      <= (wrPtr == LAST_PTR) ? '0 : wrPtr + 1'b1;
      end
      if (doPop) rdPtr <= (rdPtr == LAST_PTR) ? '0 : rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The reader's credit rule must keep pushes from ever hitting a full FIFO.
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      overflowChk: assert (!(pushIn && !doPush));
    end
  end

endmodule

// File: rtl/sp_ram_stream_reader.sv
// sp_ram_stream_reader: burst read engine in front of one sp_ram instance.
// Issues sequential reads starting at baseAddrIn for lengthIn words and
// re-emits the returned words as a valid/ready stream through stream_fifo.
// Ports:
//   clkIn, rstIn          : clock (rising edge), asynchronous active-low reset
//   startIn               : start pulse, sampled only in IDLE
//   baseAddrIn, lengthIn  : first address and word count (0..RAM_DEPTH)
//   busyOut, doneOut      : busy from accepted start through the done cycle;
//                           done is a one-cycle pulse
//   ramAddrOut, ramRdEnOut, ramWrEnOut (always 0) : RAM request side
//   ramRdDataIn, ramRdAckIn : RAM response, ack one cycle after the request
//   dataOut, validOut, readyIn : output stream
//   dbgStateOut           : current FSM state
//   stallCntOut           : present only with SP_RAM_STREAM_STALL_CNT_EN;
//                           saturating count of validOut=1/readyIn=0 cycles
//
// Stream handshake: a beat transfers in a cycle where validOut and readyIn are
// both 1. While validOut=1 and readyIn=0, dataOut and validOut hold. validOut
// never depends on readyIn in the same cycle.
module sp_ram_stream_reader
  import sp_ram_stream_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  parameter int  RAM_DEPTH  = 512,
  parameter int  FIFO_DEPTH = 2,
  localparam int ADDR_WIDTH = addrWidthOf(RAM_DEPTH),
  localparam int WE_WIDTH   = (DATA_WIDTH + 7) / 8
) (
  input  logic                  clkIn,
  input  logic                  rstIn,
  input  logic                  startIn,
  input  logic [ADDR_WIDTH-1:0] baseAddrIn,
  input  logic [ADDR_WIDTH:0]   lengthIn,
  output logic                  busyOut,
  output logic                  doneOut,
  output logic [ADDR_WIDTH-1:0] ramAddrOut,
  output logic                  ramRdEnOut,
  output logic [WE_WIDTH-1:0]   ramWrEnOut,
  input  logic [DATA_WIDTH-1:0] ramRdDataIn,
  input  logic                  ramRdAckIn,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  validOut,
  input  logic                  readyIn,
  output logic [STATE_W-1:0]    dbgStateOut
`ifdef SP_RAM_STREAM_STALL_CNT_EN
  ,
  output logic [31:0]           stallCntOut
`endif
);

  localparam int CNT_W = fifoCntWidthOf(FIFO_DEPTH);

  logic [STATE_W-1:0]    state;
  logic [ADDR_WIDTH-1:0] addrReg;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  inflight;
  logic [CNT_W-1:0]      fifoCount;
  logic [CNT_W:0]        occupancy;
  logic                  push;
  logic                  pop;
  logic                  canIssue;
  logic                  drainDone;

  assign validOut = (fifoCount != '0);
  assign pop      = validOut && readyIn;
  // Acks outside an active burst are stale (e.g. from before a reset).
  assign push     = ramRdAckIn && ((state == ST_ISSUE) || (state == ST_DRAIN));

  // Credit: words buffered plus the read still in flight, less the word
  // leaving this cycle, must leave room for one more response.
  assign occupancy = {1'b0, fifoCount} + (CNT_W + 1)'(inflight) - (CNT_W + 1)'(pop);
  assign canIssue  = occupancy < (CNT_W + 1)'(FIFO_DEPTH);

  assign ramRdEnOut = (state == ST_ISSUE) && (remaining != '0) && canIssue;
  assign ramAddrOut = addrReg;
  assign ramWrEnOut = '0;

  // Finish when nothing is in flight, nothing arrives, and the FIFO empties
  // this cycle, so done lands the cycle after the last beat.
  assign drainDone = !inflight && !push && (fifoCount == CNT_W'(pop));

  assign busyOut     = (state != ST_IDLE);
  assign doneOut     = (state == ST_DONE);
  assign dbgStateOut = state;

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      state     <= ST_IDLE;
      addrReg   <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= ramRdEnOut;
      if (ramRdEnOut) begin
        addrReg   <= addrReg + 1'b1;  // wraps modulo 2^ADDR_WIDTH
        remaining <= remaining - 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (startIn) begin
            addrReg   <= baseAddrIn;
            remaining <= lengthIn;
            state     <= (lengthIn == '0) ? ST_DONE : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (ramRdEnOut && (remaining == (ADDR_WIDTH + 1)'(1))) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (drainDone) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  stream_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clkIn      (clkIn),
    .rstIn      (rstIn),
    .pushIn     (push),
    .pushDataIn (ramRdDataIn),
    .popIn      (pop),
    .headOut    (dataOut),
    .countOut   (fifoCount)
  );

`ifdef SP_RAM_STREAM_STALL_CNT_EN
  logic [31:0] stallCnt;

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      stallCnt <= '0;
    end else if ((state == ST_IDLE) && startIn) begin
      stallCnt <= '0;
    end else if (validOut && !readyIn && (stallCnt != '1)) begin
      stallCnt <= stallCnt + 1'b1;
    end
  end

  assign stallCntOut = stallCnt;
`endif

endmodule

// File: tb/tb_sp_ram_stream_reader.sv
module tb_sp_ram_stream_reader;

  localparam int DW         = 32;
  localparam int RAM_DEPTH  = 512;
  localparam int AW         = 9;
  localparam int FIFO_DEPTH = 2;

  logic          clkIn = 1'b0;
  logic          rstIn;
  logic          startIn;
  logic [AW-1:0] baseAddrIn;
  logic [AW:0]   lengthIn;
  logic          busyOut;
  logic          doneOut;
  logic [AW-1:0] ramAddrOut;
  logic          ramRdEnOut;
  logic [3:0]    ramWrEnOut;
  logic [DW-1:0] ramRdDataIn = '0;
  logic          ramRdAckIn = 1'b0;
  logic [DW-1:0] dataOut;
  logic          validOut;
  logic          readyIn;
  logic [1:0]    dbgStateOut;
`ifdef SP_RAM_STREAM_STALL_CNT_EN
  logic [31:0]   stallCntOut;
`endif

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ram [RAM_DEPTH];

  // ---------------- clock / reset ----------------
  always #5 clkIn = ~clkIn;

  sp_ram_stream_reader #(
    .DATA_WIDTH (DW),
    .RAM_DEPTH  (RAM_DEPTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clkIn       (clkIn),
    .rstIn       (rstIn),
    .startIn     (startIn),
    .baseAddrIn  (baseAddrIn),
    .lengthIn    (lengthIn),
    .busyOut     (busyOut),
    .doneOut     (doneOut),
    .ramAddrOut  (ramAddrOut),
    .ramRdEnOut  (ramRdEnOut),
    .ramWrEnOut  (ramWrEnOut),
    .ramRdDataIn (ramRdDataIn),
    .ramRdAckIn  (ramRdAckIn),
    .dataOut     (dataOut),
    .validOut    (validOut),
    .readyIn     (readyIn),
    .dbgStateOut (dbgStateOut)
`ifdef SP_RAM_STREAM_STALL_CNT_EN
    ,
    .stallCntOut (stallCntOut)
`endif
  );

  // sp_ram behaviour: one-cycle read latency, ack follows the request.
  always @(posedge clkIn) begin
    ramRdAckIn  <= ramRdEnOut;
    ramRdDataIn <= ram[ramAddrOut];
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busyOut, 0);
    chk({tag, "_done"}, doneOut, 0);
    chk({tag, "_rden"}, ramRdEnOut, 0);
    chk({tag, "_addr"}, ramAddrOut, 0);
    chk({tag, "_wren"}, ramWrEnOut, 0);
    chk({tag, "_valid"}, validOut, 0);
    chk({tag, "_data"}, dataOut, 0);
    chk({tag, "_state"}, dbgStateOut, 0);
`ifdef SP_RAM_STREAM_STALL_CNT_EN
    chk({tag, "_stallcnt"}, stallCntOut, 0);
`endif
  endtask

  // ---------------- driver + reference model ----------------
  // mode 0: readyIn always 1; mode 1: pattern 1,0,0,1; mode 2: random.
  // restart_cyc > 0 pulses startIn with a different base in that cycle.
  task automatic run_burst(input int base, input int len, input int mode, input int restart_cyc);
    logic [DW-1:0] exp_q[$];
    int            exp_addr[$];
    int            issued, popped, stalls, first_rd, first_vld, done_cyc;
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    issued = 0; popped = 0; stalls = 0; first_rd = 0; first_vld = 0; done_cyc = 0;
    prev_stall = 1'b0; prev_data = '0;
    for (int i = 0; i < len; i++) begin
      exp_addr.push_back((base + i) % RAM_DEPTH);
      exp_q.push_back(ram[(base + i) % RAM_DEPTH]);
    end

    @(negedge clkIn);
    startIn    = 1'b1;
    baseAddrIn = AW'(base);
    lengthIn   = (AW + 1)'(len);
    readyIn    = 1'b1;
    @(posedge clkIn);
    #1;
    startIn = 1'b0;

    for (int cyc = 1; (cyc <= len * 8 + 20) && (done_cyc == 0); cyc++) begin
      case (mode)
        0:       readyIn = 1'b1;
        1:       readyIn = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
        default: readyIn = 1'($urandom_range(0, 1));
      endcase
      startIn = (cyc == restart_cyc);
      if (startIn) begin
        baseAddrIn = AW'(base + 100);
        lengthIn   = (AW + 1)'(7);
      end
      @(negedge clkIn);
      chk("busy_during_burst", busyOut, 1);
      chk("wr_en_zero", ramWrEnOut, 0);
      chk("outstanding_le_depth", (issued - popped) <= FIFO_DEPTH, 1);
      if (prev_stall) begin
        chk("stall_valid_hold", validOut, 1);
        chk("stall_data_hold", dataOut, prev_data);
      end
      if (ramRdEnOut) begin
        if (first_rd == 0) first_rd = cyc;
        chk("reads_within_len", issued < len, 1);
        if (exp_addr.size() > 0) chk("rd_addr", ramAddrOut, exp_addr.pop_front());
        issued++;
      end
      if (validOut && (first_vld == 0)) first_vld = cyc;
      if (validOut && readyIn) begin
        chk("beats_within_len", popped < len, 1);
        if (exp_q.size() > 0) chk("beat_data", dataOut, exp_q.pop_front());
        popped++;
      end
      prev_stall = validOut && !readyIn;
      prev_data  = dataOut;
      if (prev_stall) stalls++;
      if (doneOut) done_cyc = cyc;
      @(posedge clkIn);
      #1;
    end
    startIn = 1'b0;

    chk("done_seen", done_cyc != 0, 1);
    chk("all_reads_issued", issued, len);
    chk("all_beats_received", popped, len);
    if (mode == 0) begin
      chk("done_cycle", done_cyc, (len == 0) ? 1 : len + 3);
      if (len > 0) begin
        chk("first_read_cycle", first_rd, 1);
        chk("first_valid_cycle", first_vld, 3);
      end
    end
`ifdef SP_RAM_STREAM_STALL_CNT_EN
    chk("stall_count", stallCntOut, stalls);
`endif
    @(negedge clkIn);
    chk("busy_low_after_done", busyOut, 0);
    chk("done_single_pulse", doneOut, 0);
    chk("valid_low_after_done", validOut, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < RAM_DEPTH; i++) ram[i] = $urandom;
    rstIn      = 1'b1;
    startIn    = 1'b0;
    baseAddrIn = '0;
    lengthIn   = '0;
    readyIn    = 1'b0;
    #2 rstIn = 1'b0;
    repeat (2) @(negedge clkIn);
    chk_reset_outputs("reset");
    rstIn = 1'b1;

    run_burst(16, 4, 0, 0);          // basic timing
    run_burst(0, 0, 0, 0);           // zero length
    run_burst(RAM_DEPTH - 2, 4, 0, 0); // address wrap
    run_burst(int'($urandom_range(0, RAM_DEPTH - 1)), 8, 1, 0); // 1,0,0,1 backpressure
    run_burst(32, 4, 0, 2);          // start mid-burst ignored

    // Reset mid-burst with a read in flight; its ack arrives after reset.
    @(negedge clkIn);
    startIn = 1'b1; baseAddrIn = AW'(200); lengthIn = (AW + 1)'(6); readyIn = 1'b0;
    @(posedge clkIn); #1; startIn = 1'b0;
    @(posedge clkIn); #1;
    @(posedge clkIn); #1;
    rstIn = 1'b0;
    #1;
    chk_reset_outputs("midburst_reset");
    #1 rstIn = 1'b1;
    readyIn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clkIn);
      chk("post_reset_valid", validOut, 0);
      chk("post_reset_busy", busyOut, 0);
      chk("post_reset_rden", ramRdEnOut, 0);
    end

    run_burst(int'($urandom_range(0, RAM_DEPTH - 1)), 5, 0, 0); // fresh burst
    for (int t = 0; t < 4; t++)
      run_burst(int'($urandom_range(0, RAM_DEPTH - 1)), int'($urandom_range(1, 12)), 2, 0);
    run_burst(int'($urandom_range(0, RAM_DEPTH - 1)), RAM_DEPTH, 0, 0); // full RAM

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sp_ram_stream_reader.md
Name: sp_ram_stream_reader

Overview:
- Burst read engine upstream of sp_ram. It issues sequential read requests to one sp_ram instance and re-emits the returned words as a valid/ready stream.
- A small FIFO absorbs the RAM's 1-cycle read latency, so downstream backpressure never drops data.
- Feeds accelerator datapath stages that consume operand vectors.

Parameters:
- DATA_WIDTH, 32: RAM word and stream width.
- RAM_DEPTH, 512: words in the attached RAM. ADDR_WIDTH = $clog2(RAM_DEPTH).
- FIFO_DEPTH, 2: output buffer entries. Minimum 2 for full throughput.

Ports:
- clkIn  in  1  Clock; all logic on the rising edge.
- rstIn  in  1  Reset; asynchronous, active-low.
- startIn  in  1  Start pulse; sampled only in IDLE.
- baseAddrIn  in  ADDR_WIDTH  First word address.
- lengthIn  in  ADDR_WIDTH+1  Word count, 0..RAM_DEPTH.
- busyOut  out  1  High from accepted start until done.
- doneOut  out  1  One-cycle pulse when the burst completes.
- ramAddrOut  out  ADDR_WIDTH  RAM address.
- ramRdEnOut  out  1  RAM read request.
- ramWrEnOut  out  (DATA_WIDTH+7)/8  RAM byte write enables; constant 0.
- ramRdDataIn  in  DATA_WIDTH  RAM read data.
- ramRdAckIn  in  1  RAM read acknowledge; 1 cycle after ramRdEnOut.
- dataOut  out  DATA_WIDTH  Stream data.
- validOut  out  1  Stream valid.
- readyIn  in  1  Stream ready.

Behaviour:
- Reset values: all outputs 0. FSM returns to IDLE; FIFO, counters and inflight flag are cleared.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - startIn=1 latches baseAddrIn and lengthIn.
  - lengthIn=0 -> DONE; no RAM access.
  - Otherwise -> ISSUE.
  - startIn is ignored in every other state.
- ISSUE: ramRdEnOut=1 in a cycle when remaining>0 and fifoCount + inflight - pop < FIFO_DEPTH.
  - pop = validOut & readyIn.
  - inflight = registered copy of last cycle's ramRdEnOut.
  - On each issue: address increments and remaining decrements.
- Address wraps modulo 2^ADDR_WIDTH. Example: base RAM_DEPTH-1 -> next address 0.
- ISSUE -> DRAIN when the last read is issued.
- DRAIN -> DONE when inflight=0, fifoCount=0, and no push is pending.
- DONE: doneOut=1 for exactly one cycle, busyOut drops to 0, then IDLE. A new start is accepted from the following cycle.
- ramRdAckIn=1 pushes ramRdDataIn into the FIFO in ISSUE or DRAIN only. In IDLE or DONE it is discarded; this covers stale acks from reads issued before a reset.
- Stream rules:
  - dataOut is the FIFO head and validOut = fifoCount != 0.
  - dataOut and validOut hold stable while validOut=1 and readyIn=0.
  - Push and pop in the same cycle: count unchanged, ordering preserved.
- Latency, start high in cycle 0: ramRdEnOut in cycle 1, ack in cycle 2, validOut in cycle 3.
- With readyIn held high: 1 beat/cycle. Total burst = length+3 cycles until the doneOut cycle.
- The FIFO never overflows; the credit rule guarantees it. An overflow is an assertion failure.
- Asserting rstIn mid-burst aborts immediately. No doneOut is produced and buffered data is lost.

Optional Feature:
- Macro: SP_RAM_STREAM_STALL_CNT_EN.
- When defined:
  - Adds output stallCntOut, 32 bits.
  - Counts cycles with validOut=1 and readyIn=0.
  - Clears on accepted start and on reset; saturates at 2^32-1.
  - Holds its value after done until the next start.
- When undefined: no port and no counter logic. All other behaviour is identical.

Decomposition:
- Package sp_ram_stream_pkg holds:
  - the FSM state encoding (IDLE/ISSUE/DRAIN/DONE);
  - helper width constants: ADDR_WIDTH and FIFO count width $clog2(FIFO_DEPTH+1).
- One sub-module, stream_fifo, parameterised by DATA_WIDTH and FIFO_DEPTH:
  - synchronous FIFO with push, pop, head data and count;
  - same clock and reset as the parent.

Test Plan:
- base=0x010, length=4, readyIn=1 -> reads at 0x010..0x013 in cycles 1-4; data beats in cycles 3-6; doneOut in cycle 7; busyOut low in cycle 8.
- length=0 -> no ramRdEnOut; doneOut in cycle 1; validOut never high.
- base=RAM_DEPTH-2=510, length=4 -> address sequence 510, 511, 0, 1; data order matches.
- length=8 with readyIn toggling 1,0,0,1,... -> all 8 words arrive in order. Never more than 2 outstanding (fifo+inflight). dataOut is stable while stalled. With the macro defined, stallCntOut equals the count of stall cycles.
- startIn pulsed again mid-burst with a different base -> ignored; the original 4-word burst completes unchanged.
- rstIn low mid-burst with one read in flight, then high -> outputs 0. The stale ack is discarded and validOut stays 0. The next start behaves as a fresh burst.
